ysyx_23060229_mdu: RTL

- Multi-cycle RV32M multiply/divide unit, parametrised in XLEN.
- Runs beside the EXU. The EXU hands off any M-type op (MUL…REMU) over a valid/ready handshake, then stalls until the result returns.
- Results come back on a second valid/ready channel, so the unit supports backpressure and pipeline flush.

---
 rtl/ysyx_23060229_mdu_pkg.sv | 35 +++
 rtl/ysyx_23060229_mdu_div_iter.sv | 50 +++++
 rtl/ysyx_23060229_mdu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060229_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and operand-signedness helpers.
package ysyx_23060229_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // MUL keeps unsigned magnitudes: its low half is the same either way.
    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_rs2(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ysyx_23060229_mdu_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// quo_o/rem_o give the values after the step being taken this cycle.
module ysyx_23060229_div_iter
    import ysyx_23060229_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   trial;
    logic            fits;

    // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
        fits  = !trial[XLEN];
        rem_d = fits ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], fits};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quo_o = quo_d;
    assign rem_o = rem_d;

endmodule

// File: rtl/ysyx_23060229_mdu.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready in and out.
// Define YSYX_23060229_FAST_MUL_EN for single-cycle combinational multiply.
module ysyx_23060229_mdu
    import ysyx_23060229_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q;
    logic [2:0]        op_q;
    logic              s1_q, s2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] mcand_q, prod_q, prod_d, prod_fix;
    logic [XLEN-1:0]   mplier_q;

    logic              accept, s1, s2, div_by_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2, special_res;
    logic [XLEN-1:0]   quo_raw, rem_raw, quo_fix, rem_fix, calc_res;

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    always_comb begin
        s1   = is_signed(op) && src1[XLEN-1];
        s2   = is_signed_rs2(op) && src2[XLEN-1];
        abs1 = s1 ? -src1 : src1;
        abs2 = s2 ? -src2 : src2;
        div_by_zero = is_div(op) && (src2 == '0);
        div_ovf     = is_div(op) && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
        if (div_by_zero) special_res = op[1] ? src1 : '1;
        else             special_res = op[1] ? '0 : src1;
    end

`ifdef YSYX_23060229_FAST_MUL_EN
    // 2*XLEN-bit signed product of sign-extended operands; identical in the
    // bits we use to an (XLEN+1)x(XLEN+1) signed multiply.
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
    logic [XLEN-1:0]          fast_res;
    always_comb begin
        fast_a   = $signed({{XLEN{is_signed(op) && src1[XLEN-1]}}, src1});
        fast_b   = $signed({{XLEN{is_signed_rs2(op) && src2[XLEN-1]}}, src2});
        fast_p   = fast_a * fast_b;
        fast_res = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    ysyx_23060229_div_iter #(.XLEN(XLEN)) u_div (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (accept && is_div(op)),
        .step_i     ((state_q == ST_CALC) && is_div(op_q)),
        .dividend_i (abs1),
        .divisor_i  (abs2),
        .quo_o      (quo_raw),
        .rem_o      (rem_raw)
    );

    // Sign fix-up uses the post-step values so the last iteration lands in DONE.
    always_comb begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        prod_fix = (s1_q ^ s2_q) ? -prod_d : prod_d;
        quo_fix  = (s1_q ^ s2_q) ? -quo_raw : quo_raw;
        rem_fix  = s1_q ? -rem_raw : rem_raw;
        if (is_div(op_q))        calc_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == OP_MUL) calc_res = prod_fix[XLEN-1:0];
        else                     calc_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        s1_q     <= s1;
                        s2_q     <= s2;
                        mcand_q  <= {{XLEN{1'b0}}, abs1};
                        mplier_q <= abs2;
                        prod_q   <= '0;
                        cnt_q    <= CNT_W'(XLEN - 1);
                        if (div_by_zero || div_ovf) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= special_res;
                        end
`ifdef YSYX_23060229_FAST_MUL_EN
                        else if (!is_div(op)) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= fast_res;
                        end
`endif
                        else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                    prod_q   <= prod_d;
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= calc_res;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
